// File: rtl/req_tag_sched_if.sv
// rtl/req_tag_sched_if.sv - request/grant, table init/update and completion signals of req_tag_sched
// slave is the scheduler side; master is the requester/table environment.
interface req_tag_sched_if #(
  parameter int NUM_REQ     = 4,
  parameter int TAG_WIDTH   = 3,
  parameter int HIS_WIDTH_I = 4
);
  logic [NUM_REQ-1:0]             req_vld;
  logic [NUM_REQ*HIS_WIDTH_I-1:0] req_his;
  logic [NUM_REQ-1:0]             req_gnt;
  logic [TAG_WIDTH-1:0]           gnt_tag;
  logic                           init_vld;
  logic [TAG_WIDTH-1:0]           init_tag;
  logic [HIS_WIDTH_I-1:0]         init_his;
  logic                           cpl_vld;
  logic [TAG_WIDTH-1:0]           cpl_tag;
  logic                           update_vld;
  logic [TAG_WIDTH-1:0]           update_tag;
  logic                           err_spurious;

  modport master (
    output req_vld, req_his, cpl_vld, cpl_tag,
    input  req_gnt, gnt_tag, init_vld, init_tag, init_his, update_vld, update_tag, err_spurious
  );

  modport slave (
    input  req_vld, req_his, cpl_vld, cpl_tag,
    output req_gnt, gnt_tag, init_vld, init_tag, init_his, update_vld, update_tag, err_spurious
  );
endinterface

// File: rtl/req_tag_sched.sv
// rtl/req_tag_sched.sv - round-robin issue scheduler allocating history-table tags
// Grants are registered; completions retire tags combinationally through the update port.
module req_tag_sched #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_COUNT = 8,
  parameter int HIS_WIDTH = 4,
  localparam int HIS_WIDTH_I = (HIS_WIDTH != 0) ? HIS_WIDTH : 1,
  localparam int TAG_WIDTH   = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1,
  localparam int CNT_WIDTH   = $clog2(TAG_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 drain_req,
  req_tag_sched_if.slave       bus,
  output logic                 drain_done,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 tags_full
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state, state_nxt;
  logic [TAG_COUNT-1:0]   busy, busy_nxt;
  logic [PTR_W-1:0]       ptr, idx, gnt_idx;
  logic [NUM_REQ-1:0]     elig, req_gnt;
  logic                   gnt_any, free_any, gnt_go, legal;
  logic [TAG_WIDTH-1:0]   free_tag, gnt_tag, init_tag;
  logic                   init_vld;
  logic [HIS_WIDTH_I-1:0] init_his, his_sel;

  // A requester granted this cycle is masked so it cannot win twice in a row.
  assign elig = bus.req_vld & ~req_gnt;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_tag = '0;
    for (int t = TAG_COUNT - 1; t >= 0; t--) begin
      if (!busy[t]) begin
        free_any = 1'b1;
        free_tag = TAG_WIDTH'(t);
      end
    end
  end

  assign gnt_go  = (state == S_RUN) && gnt_any && free_any;
  assign his_sel = (HIS_WIDTH == 0) ? '0 : bus.req_his[gnt_idx*HIS_WIDTH_I +: HIS_WIDTH_I];

  // A tag being initialised this cycle cannot legally complete yet.
  assign legal = bus.cpl_vld && busy[bus.cpl_tag] && !(init_vld && init_tag == bus.cpl_tag);

  always_comb begin
    busy_nxt = busy;
    if (legal) busy_nxt[bus.cpl_tag] = 1'b0;
    if (gnt_go) busy_nxt[free_tag] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_RUN;
      S_RUN:   if (drain_req) state_nxt = S_DRAIN;
               else if (!enable) state_nxt = S_IDLE;
      S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
      S_DONE:  if (!drain_req) state_nxt = enable ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= '0;
      ptr         <= '0;
      req_gnt     <= '0;
      gnt_tag     <= '0;
      init_vld    <= 1'b0;
      init_tag    <= '0;
      init_his    <= '0;
      outstanding <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      req_gnt  <= '0;
      init_vld <= 1'b0;
      if (gnt_go) begin
        req_gnt  <= NUM_REQ'(1) << gnt_idx;
        gnt_tag  <= free_tag;
        init_vld <= 1'b1;
        init_tag <= free_tag;
        init_his <= his_sel;
        ptr      <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      outstanding <= outstanding + CNT_WIDTH'(gnt_go) - CNT_WIDTH'(legal);
    end
  end

  assign bus.req_gnt      = req_gnt;
  assign bus.gnt_tag      = gnt_tag;
  assign bus.init_vld     = init_vld;
  assign bus.init_tag     = init_tag;
  assign bus.init_his     = init_his;
  assign bus.update_vld   = legal;
  assign bus.update_tag   = bus.cpl_tag;
  assign bus.err_spurious = bus.cpl_vld && !legal;
  assign drain_done       = (state == S_DONE);
  assign tags_full        = (outstanding == CNT_WIDTH'(TAG_COUNT));
endmodule

// File: tb/tb_req_tag_sched.sv
// tb/tb_req_tag_sched.sv - directed and random bench for req_tag_sched against a tag-set model
module tb_req_tag_sched;
  localparam int NR = 4;
  localparam int TC = 8;
  localparam int HW = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       drain_req = 1'b0;
  logic       drain_done, tags_full;
  logic [3:0] outstanding;

  req_tag_sched_if #(.NUM_REQ(NR), .TAG_WIDTH(3), .HIS_WIDTH_I(HW)) bus ();

  req_tag_sched #(.NUM_REQ(NR), .TAG_COUNT(TC), .HIS_WIDTH(HW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .drain_req(drain_req), .bus(bus),
    .drain_done(drain_done), .outstanding(outstanding), .tags_full(tags_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of busy tags, requester that was granted, and the drain state.
  bit         m_busy[TC];
  int         m_state, m_ptr, m_gnt, m_tag;
  logic [3:0] m_his;

  function automatic int busy_count();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_state = M_IDLE;
    m_ptr = 0;
    m_gnt = -1;
    m_tag = 0;
    m_his = '0;
  endtask

  task automatic step(input bit en, input logic [3:0] rv, input logic [15:0] rh,
                      input bit cv, input int ct, input bit dr);
    bit         legal;
    int         cnt, free, ng, nt, ns, r;
    logic [3:0] nh;
    @(negedge clk);
    enable = en;
    drain_req = dr;
    bus.req_vld = rv;
    bus.req_his = rh;
    bus.cpl_vld = cv;
    bus.cpl_tag = 3'(ct);
    #1;
    cnt = busy_count();
    legal = cv && m_busy[ct] && !(m_gnt >= 0 && m_tag == ct);
    check("req_gnt", 32'(bus.req_gnt), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    check("init_vld", 32'(bus.init_vld), 32'(m_gnt >= 0));
    if (m_gnt >= 0) begin
      check("gnt_tag", 32'(bus.gnt_tag), 32'(m_tag));
      check("init_tag", 32'(bus.init_tag), 32'(m_tag));
      check("init_his", 32'(bus.init_his), 32'(m_his));
    end
    check("outstanding", 32'(outstanding), 32'(cnt));
    check("tags_full", 32'(tags_full), 32'(cnt == TC));
    check("drain_done", 32'(drain_done), 32'(m_state == M_DONE));
    check("update_vld", 32'(bus.update_vld), 32'(legal));
    check("err_spurious", 32'(bus.err_spurious), 32'(cv && !legal));
    if (legal) check("update_tag", 32'(bus.update_tag), 32'(ct));

    ng = -1; nt = 0; nh = m_his; free = -1;
    if (m_state == M_RUN) begin
      for (int t = 0; t < TC; t++) if (free < 0 && !m_busy[t]) free = t;
      if (free >= 0) begin
        for (int k = 0; k < NR; k++) begin
          r = (m_ptr + k) % NR;
          if (ng < 0 && rv[r] && r != m_gnt) ng = r;
        end
      end
      if (ng >= 0) begin
        nt = free;
        nh = rh[ng*4 +: 4];
      end
    end
    ns = m_state;
    case (m_state)
      M_IDLE:  if (en) ns = M_RUN;
      M_RUN:   if (dr) ns = M_DRAIN; else if (!en) ns = M_IDLE;
      M_DRAIN: if (cnt == 0) ns = M_DONE;
      default: if (!dr) ns = en ? M_RUN : M_IDLE;
    endcase

    @(posedge clk);
    if (legal) m_busy[ct] = 1'b0;
    if (ng >= 0) begin
      m_busy[nt] = 1'b1;
      m_ptr = (ng + 1) % NR;
      m_tag = nt;
    end
    m_gnt = ng;
    m_his = nh;
    m_state = ns;
  endtask

  // Reset is applied mid-cycle so the asynchronous clear is visible before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    bus.cpl_vld = 1'b0;
    bus.req_vld = '0;
    enable = 1'b0;
    drain_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_gnt", 32'(bus.req_gnt), 32'd0);
    check("rst_init_vld", 32'(bus.init_vld), 32'd0);
    check("rst_init_tag", 32'(bus.init_tag), 32'd0);
    check("rst_gnt_tag", 32'(bus.gnt_tag), 32'd0);
    check("rst_init_his", 32'(bus.init_his), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_tags_full", 32'(tags_full), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_update_vld", 32'(bus.update_vld), 32'd0);
    check("rst_err", 32'(bus.err_spurious), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit dr_lvl;
    bus.req_vld = '0;
    bus.req_his = '0;
    bus.cpl_vld = 1'b0;
    bus.cpl_tag = '0;
    model_reset();
    do_reset();

    // Single request: granted two cycles after enable.
    step(1, 4'b0001, 16'h000A, 0, 0, 0);
    step(1, 4'b0001, 16'h000A, 0, 0, 0);
    #1;
    check("first_gnt", 32'(bus.req_gnt), 32'b0001);
    check("first_tag", 32'(bus.init_tag), 32'd0);
    check("first_his", 32'(bus.init_his), 32'hA);
    check("first_outstanding", 32'(outstanding), 32'd1);

    // Fill all tags with every requester asserting.
    for (int i = 0; i < 20; i++) step(1, 4'b1111, 16'h4321, 0, 0, 0);
    #1;
    check("full_flag", 32'(tags_full), 32'd1);
    check("full_count", 32'(outstanding), 32'd8);

    // Retire tag 3 and let it be reused.
    step(1, 4'b1111, 16'h8765, 1, 3, 0);
    for (int i = 0; i < 4; i++) step(1, 4'b1111, 16'h8765, 0, 0, 0);

    // Retire tag 5, then complete it again while free.
    step(1, 4'b0000, 16'h0, 1, 5, 0);
    step(1, 4'b0000, 16'h0, 0, 0, 0);
    step(1, 4'b0000, 16'h0, 1, 5, 0);
    step(1, 4'b0000, 16'h0, 0, 0, 0);

    // Drain with three tags outstanding.
    do_reset();
    step(1, 4'b0000, 16'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'b0111, 16'h0CB0, 0, 0, 0);
    step(1, 4'b0000, 16'h0, 0, 0, 1);
    for (int t = 0; t < 3; t++) step(1, 4'b1111, 16'h0, 1, t, 1);
    step(1, 4'b1111, 16'h0, 0, 0, 1);
    step(1, 4'b1111, 16'h0, 0, 0, 1);
    #1;
    check("drain_done_set", 32'(drain_done), 32'd1);
    check("drain_outstanding", 32'(outstanding), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 4'b1111, 16'h1111, 0, 0, 0);

    // Grant and legal completion in the same cycle at seven outstanding.
    do_reset();
    step(1, 4'b0000, 16'h0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 4'b1111, 16'h2468, 0, 0, 0);
    step(1, 4'b1111, 16'h2468, 1, 0, 0);
    #1;
    check("net_zero_outstanding", 32'(outstanding), 32'd7);
    step(1, 4'b0000, 16'h0, 0, 0, 0);

    // Random traffic with an asynchronous reset in the middle of it.
    dr_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) dr_lvl = !dr_lvl;
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) != 0, 4'($urandom), 16'($urandom),
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), dr_lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
